traffic_ctrl: RTL and testbench



---
 rtl/traffic_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_traffic_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: packet traffic injector for a NoC node.
//
// Waits in GAP drawing pseudo-random values until one falls below RATE.
// It then emits a NUM_FLITS packet (head, bodies, tail) with valid/ready
// handshaking. A stop request never truncates a packet in flight.
//
// Parameters:
//   NUM_FLITS  flits per packet including head and tail (2..63)
//   RATE       inject threshold, a packet starts when lfsr_val < RATE
//   SRC_ID     node ID of this injector
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   start        pulse, begin generating traffic (ignored while busy)
//   stop         pulse, stop after the current packet
//   lfsr_val     current pseudo-random value
//   lfsr_en      advance the pseudo-random generator this cycle
//   flit_out     registered flit data
//   flit_valid   flit_out is valid
//   flit_ready   sink accepts the flit
//   pkt_count    completed packets, wraps
//   busy         FSM is not in IDLE
//   stall_count  backpressure cycles, saturating
//
// Build option: define TRAFFIC_STATS_EN to include the stall counter.
// Without it, stall_count is tied to zero.
//
// state | meaning
// IDLE  | not generating, waiting for start
// GAP   | drawing random values until an inject decision
// HEAD  | presenting the head flit
// BODY  | presenting a body flit
// TAIL  | presenting the tail flit

module traffic_ctrl #(
    parameter int          NUM_FLITS = 4,
    parameter logic [7:0]  RATE      = 8'd64,
    parameter logic [3:0]  SRC_ID    = 4'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  lfsr_val,
    output logic        lfsr_en,
    output logic [15:0] flit_out,
    output logic        flit_valid,
    input  logic        flit_ready,
    output logic [15:0] pkt_count,
    output logic        busy,
    output logic [15:0] stall_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GAP  = 3'd1,
        HEAD = 3'd2,
        BODY = 3'd3,
        TAIL = 3'd4
    } state_t;

    // Bodies still to send after the first one. This is unused when NUM_FLITS == 2.
    localparam logic [5:0] BODY_INIT = 6'(NUM_FLITS - 3);

    state_t      state_q, state_d;
    logic [15:0] flit_q, flit_d;
    logic [15:0] pkt_q, pkt_d;
    logic [5:0]  seq_q, seq_d;
    logic [5:0]  body_rem_q, body_rem_d;
    logic        stop_pend_q, stop_pend_d;

    logic [3:0]  dest;
    logic [8:0]  rate_diff;
    logic        inject;

    // lfsr_val < RATE is read from the borrow of a 9-bit subtraction.
    assign rate_diff = {1'b0, lfsr_val} - {1'b0, RATE};
    assign inject    = rate_diff[8];

    // A packet never targets its own node.
    assign dest = (lfsr_val[3:0] == SRC_ID) ? (lfsr_val[3:0] ^ 4'b0001)
                                            : lfsr_val[3:0];

    assign flit_valid = (state_q == HEAD) || (state_q == BODY) || (state_q == TAIL);
    assign busy       = (state_q != IDLE);
    assign flit_out   = flit_q;
    assign pkt_count  = pkt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flit_q      <= 16'h0000;
            pkt_q       <= 16'h0000;
            seq_q       <= 6'd0;
            body_rem_q  <= 6'd0;
            stop_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flit_q      <= flit_d;
            pkt_q       <= pkt_d;
            seq_q       <= seq_d;
            body_rem_q  <= body_rem_d;
            stop_pend_q <= stop_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flit_d      = flit_q;
        pkt_d       = pkt_q;
        seq_d       = seq_q;
        body_rem_d  = body_rem_q;
        stop_pend_d = stop_pend_q;
        lfsr_en     = 1'b0;

        // A stop during a packet is remembered until the tail is accepted.
        if (flit_valid && stop)
            stop_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                stop_pend_d = 1'b0;
                if (start && !stop)
                    state_d = GAP;
            end
            GAP: begin
                lfsr_en = 1'b1;
                if (stop) begin
                    state_d     = IDLE;
                    stop_pend_d = 1'b0;
                end else if (inject) begin
                    state_d = HEAD;
                    flit_d  = {2'b01, dest, SRC_ID, seq_q};
                end
            end
            HEAD: begin
                lfsr_en = flit_ready;
                if (flit_ready) begin
                    if (NUM_FLITS == 2) begin
                        state_d = TAIL;
                        flit_d  = {2'b10, seq_q, lfsr_val};
                    end else begin
                        state_d    = BODY;
                        flit_d     = {2'b00, seq_q, lfsr_val};
                        body_rem_d = BODY_INIT;
                    end
                end
            end
            BODY: begin
                lfsr_en = flit_ready;
                if (flit_ready) begin
                    if (body_rem_q == 6'd0) begin
                        state_d = TAIL;
                        flit_d  = {2'b10, seq_q, lfsr_val};
                    end else begin
                        state_d    = BODY;
                        flit_d     = {2'b00, seq_q, lfsr_val};
                        body_rem_d = body_rem_q - 6'd1;
                    end
                end
            end
            TAIL: begin
                lfsr_en = flit_ready;
                if (flit_ready) begin
                    pkt_d = pkt_q + 16'd1;
                    seq_d = seq_q + 6'd1;
                    if (stop_pend_q || stop) begin
                        state_d     = IDLE;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef TRAFFIC_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_q <= 16'h0000;
        else if (flit_valid && !flit_ready && (stall_q != 16'hFFFF))
            stall_q <= stall_q + 16'd1;
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl. It runs three instances on shared stimulus:
//   u_a  : NUM_FLITS=4, RATE=255, SRC_ID=0 (main packet flow)
//   u_r0 : NUM_FLITS=4, RATE=0,   SRC_ID=0 (never injects)
//   u_s3 : NUM_FLITS=2, RATE=255, SRC_ID=3 (dest remap, two-flit packet)
// Inputs change and outputs are sampled on the falling clock edge.

module tb_traffic_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, stop, flit_ready;
    logic [7:0]  lfsr_val;

    logic        a_lfsr_en, a_valid, a_busy;
    logic [15:0] a_flit, a_pkt, a_stall;
    logic        r_lfsr_en, r_valid, r_busy;
    logic [15:0] r_flit, r_pkt, r_stall;
    logic        s_lfsr_en, s_valid, s_busy;
    logic [15:0] s_flit, s_pkt, s_stall;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef TRAFFIC_STATS_EN
    localparam logic [15:0] EXP_STALL = 16'd5;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
`endif

    always #5 clk = ~clk;

    traffic_ctrl #(.NUM_FLITS(4), .RATE(8'd255), .SRC_ID(4'd0)) u_a (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lfsr_val(lfsr_val),
        .lfsr_en(a_lfsr_en), .flit_out(a_flit), .flit_valid(a_valid),
        .flit_ready(flit_ready), .pkt_count(a_pkt), .busy(a_busy), .stall_count(a_stall)
    );

    traffic_ctrl #(.NUM_FLITS(4), .RATE(8'd0), .SRC_ID(4'd0)) u_r0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lfsr_val(lfsr_val),
        .lfsr_en(r_lfsr_en), .flit_out(r_flit), .flit_valid(r_valid),
        .flit_ready(flit_ready), .pkt_count(r_pkt), .busy(r_busy), .stall_count(r_stall)
    );

    traffic_ctrl #(.NUM_FLITS(2), .RATE(8'd255), .SRC_ID(4'd3)) u_s3 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .lfsr_val(lfsr_val),
        .lfsr_en(s_lfsr_en), .flit_out(s_flit), .flit_valid(s_valid),
        .flit_ready(flit_ready), .pkt_count(s_pkt), .busy(s_busy), .stall_count(s_stall)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int nv, ne;
        logic [15:0] f;

        reset = 1'b1; start = 1'b0; stop = 1'b0; flit_ready = 1'b1; lfsr_val = 8'h05;
        step(); step();
        chk("rst_valid", 16'(a_valid), 16'd0);
        chk("rst_busy",  16'(a_busy), 16'd0);
        chk("rst_lfsr_en", 16'(a_lfsr_en), 16'd0);
        chk("rst_flit",  a_flit, 16'h0000);
        chk("rst_pkt",   a_pkt, 16'h0000);
        chk("rst_stall", a_stall, 16'h0000);
        reset = 1'b0;

        // Packet 0: head, two bodies, tail on consecutive cycles.
        start = 1'b1; step(); start = 1'b0;
        chk("gap_busy", 16'(a_busy), 16'd1);
        chk("gap_valid", 16'(a_valid), 16'd0);
        chk("gap_lfsr_en", 16'(a_lfsr_en), 16'd1);
        step();
        chk("p0_head", a_flit, 16'h5400);
        chk("p0_head_valid", 16'(a_valid), 16'd1);
        chk("head_lfsr_en", 16'(a_lfsr_en), 16'd1);
        lfsr_val = 8'h11; step();
        chk("p0_body1", a_flit, 16'h0011);
        lfsr_val = 8'h22; step();
        chk("p0_body2", a_flit, 16'h0022);
        lfsr_val = 8'h33; step();
        chk("p0_tail", a_flit, 16'h8033);
        step();
        chk("p0_pkt", a_pkt, 16'd1);
        chk("p0_gap_valid", 16'(a_valid), 16'd0);
        chk("p0_gap_busy", 16'(a_busy), 16'd1);

        // Packet 1: seq=1, dest=3, then a 5-cycle stall in the first body.
        step();
        chk("p1_head", a_flit, 16'h4C01);
        lfsr_val = 8'h44; step();
        chk("p1_body1", a_flit, 16'h0144);
        flit_ready = 1'b0; lfsr_val = 8'h55;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_hold", a_flit, 16'h0144);
            if (i == 0) chk("stall_lfsr_en", 16'(a_lfsr_en), 16'd0);
        end
        chk("stall_count", a_stall, EXP_STALL);

        // A stop pulse in the first body lets the packet finish.
        flit_ready = 1'b1; stop = 1'b1; lfsr_val = 8'h66; step(); stop = 1'b0;
        chk("stop_body2", a_flit, 16'h0166);
        chk("stop_body2_valid", 16'(a_valid), 16'd1);
        step();
        chk("stop_tail", a_flit, 16'h8166);
        step();
        chk("stop_idle_busy", 16'(a_busy), 16'd0);
        chk("stop_pkt", a_pkt, 16'd2);
        step();
        chk("stop_stay_idle", 16'(a_busy), 16'd0);

        // start and stop together keep the FSM in IDLE.
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        chk("startstop_busy", 16'(a_busy), 16'd0);
        step();
        chk("startstop_busy2", 16'(a_busy), 16'd0);

        // With RATE=255, lfsr_val=FF never injects. A stop in GAP returns to IDLE.
        lfsr_val = 8'hFF; start = 1'b1; step(); start = 1'b0;
        repeat (5) step();
        chk("ff_busy", 16'(a_busy), 16'd1);
        chk("ff_valid", 16'(a_valid), 16'd0);
        chk("ff_lfsr_en", 16'(a_lfsr_en), 16'd1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("gap_stop_busy", 16'(a_busy), 16'd0);

        // With RATE=0, no packet is sent over 300 GAP cycles.
        reset = 1'b1; step(); reset = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        nv = 0; ne = 0;
        for (int i = 0; i < 300; i++) begin
            lfsr_val = 8'(i);
            if (r_valid) nv++;
            if (r_busy && r_lfsr_en) ne++;
            step();
        end
        chk("r0_valid_cycles", 16'(nv), 16'd0);
        chk("r0_lfsr_en_cycles", 16'(ne), 16'd300);
        chk("r0_pkt", r_pkt, 16'd0);
        chk("r0_busy", 16'(r_busy), 16'd1);
        stop = 1'b1; step(); stop = 1'b0;

        // A reset in BODY abandons the packet. The next packet restarts at seq 0.
        reset = 1'b1; step(); reset = 1'b0;
        lfsr_val = 8'h05; start = 1'b1; step(); start = 1'b0;
        step();
        step();
        chk("pre_rst_body", a_flit[15:14], 16'd0);
        reset = 1'b1; step();
        chk("mid_rst_valid", 16'(a_valid), 16'd0);
        chk("mid_rst_busy", 16'(a_busy), 16'd0);
        chk("mid_rst_pkt", a_pkt, 16'd0);
        reset = 1'b0;
        lfsr_val = 8'h13; start = 1'b1; step(); start = 1'b0;
        step();
        chk("post_rst_head", a_flit, 16'h4C00);
        chk("s3_head", s_flit, 16'h48C0);
        f = s_flit;
        chk("s3_dest", 16'(f[13:10]), 16'h0002);
        lfsr_val = 8'h77; step();
        chk("s3_tail", s_flit, 16'h8077);
        chk("s3_tail_valid", 16'(s_valid), 16'd1);
        step();
        chk("s3_pkt", s_pkt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
